// File: rtl/rng_share_arbiter.sv
// Round-robin arbiter handing each fresh random word to exactly one requester.
// A word is consumed by a single req/ack grant; unclaimed words are overwritten.
module rng_share_arbiter #(
  parameter int N_REQ  = 4,
  parameter int WORD_W = 20,
  parameter int ID_W   = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WORD_W-1:0] rnd_word,
  input  logic [N_REQ-1:0]  req,
  output logic [N_REQ-1:0]  ack,
  output logic [WORD_W-1:0] rnd_out,
  output logic [ID_W-1:0]   grant_id,
  output logic              fresh,
  output logic [15:0]       grant_cnt
);

  localparam logic [0:0] WAIT_WORD = 1'b0;
  localparam logic [0:0] HAVE_WORD = 1'b1;

  logic [0:0]        state;
  logic [WORD_W-1:0] last_word;
  logic [ID_W-1:0]   ptr;
  logic [ID_W-1:0]   win;
  logic [ID_W-1:0]   win_nxt;
  logic [ID_W-1:0]   idx;
  logic              found;
  logic              grant;
  logic              new_word;
  int                j;

  assign fresh = (state == HAVE_WORD);

  // first set request bit at or after ptr, wrapping
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = '0;
    j     = 0;
    for (int i = 0; i < N_REQ; i++) begin
      j = int'(ptr) + i;
      if (j >= N_REQ) j = j - N_REQ;
      idx = ID_W'(j);
      if (!found && req[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  assign win_nxt  = (win == ID_W'(N_REQ - 1)) ? '0 : win + ID_W'(1);
  assign grant    = fresh && found;
  assign new_word = (rnd_word != last_word);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= WAIT_WORD;
      last_word <= '0;
      ptr       <= '0;
      ack       <= '0;
      rnd_out   <= '0;
      grant_id  <= '0;
      grant_cnt <= '0;
    end else begin
      ack <= '0;
      if (grant) begin
        ack       <= {{(N_REQ-1){1'b0}}, 1'b1} << win;
        rnd_out   <= last_word;
        grant_id  <= win;
        ptr       <= win_nxt;
        grant_cnt <= grant_cnt + 16'd1;
      end
      // a word arriving on the grant edge stays available for the next one
      if (new_word) begin
        last_word <= rnd_word;
        state     <= HAVE_WORD;
      end else if (grant) begin
        state     <= WAIT_WORD;
      end
    end
  end

endmodule

// File: doc/rng_share_arbiter.md
Name: rng_share_arbiter

Overview:
Shares the single free-running 20-bit LFSR word among several game-logic requesters, such as the obstacle spawner, lane picker and coin placer. The LFSR publishes a new word every 21 clocks. This block hands each new word to exactly one requester, using round-robin arbitration and a req/ack handshake, so two consumers never receive the same word. It sits between the random generator output and the spawn/placement controllers.

Parameters:
N_REQ, 4, number of requesters (>=2)
WORD_W, 20, width of the random word input and output
ID_W, 2, width of grant_id; must equal clog2(N_REQ)

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-high reset
rnd_word  input  WORD_W  current word from the random generator; changes at most once per 21 clocks, otherwise held
req  input  N_REQ  per-requester request; bit k is held high until ack[k]
ack  output  N_REQ  one-cycle grant pulse; at most one bit high per cycle
rnd_out  output  WORD_W  word delivered to the granted requester; valid in the cycle ack is high, held afterwards
grant_id  output  ID_W  index of the last granted requester; valid with ack, held afterwards
fresh  output  1  an unconsumed word is available
grant_cnt  output  16  total grants since reset; wraps from 0xFFFF to 0

Behaviour:
- Reset is asynchronous and active-high. While asserted, and immediately on assertion:
  - last_word, rnd_out, grant_id, grant_cnt = 0
  - fresh = 0, ack = 0, round-robin pointer ptr = 0
- Reset mid-handshake: ack drops at once and a pending word is discarded. After release, a word only counts as fresh when rnd_word differs from 0.
- New-word detect, at each rising edge:
  - If rnd_word != last_word, then last_word <= rnd_word and fresh <= 1.
  - A repeat of the same value is not fresh.
- Grant, at each rising edge, when fresh==1 and req != 0:
  - The winner k is the first set bit of req, searching ptr, ptr+1, … , N_REQ-1, 0, … (mod N_REQ).
  - Registered results: ack <= one-hot(k), rnd_out <= last_word, grant_id <= k, ptr <= (k+1) mod N_REQ, grant_cnt <= grant_cnt+1, fresh <= 0.
- Otherwise ack <= 0. ack is never high in two consecutive cycles for the same word.
- Simultaneous new word and grant on the same edge:
  - rnd_out gets the OLD last_word.
  - last_word takes the new value and fresh stays 1.
  - A second grant may then occur on the next edge.
- Latency:
  - rnd_word changes before edge E with a request pending → ack high after edge E+1. E latches the word and sets fresh; E+1 grants.
  - Request raised while fresh==1 → ack after the next edge.
- Handshake rules:
  - A requester must hold req[k] until it samples ack[k]=1, then drop req[k] on the following cycle. If it keeps req high, it is treated as a new request and competes for the next fresh word.
  - Dropping req before ack withdraws the request silently; no ack is issued and the word stays fresh.
- No requests: fresh stays 1 and the word is retained. A later rnd_word change overwrites last_word; the overwritten word is never delivered and is not counted.
- fresh==0 with requests pending: requesters wait and ack stays 0. There is no starvation; with a continuous request, a requester waits at most N_REQ fresh words.
- Implementation: fully synchronous apart from the reset, with no combinational path from req to ack. Two states: WAIT_WORD (fresh=0) and HAVE_WORD (fresh=1).

Test Plan:
- Reset, then rnd_word=0x00001 with req=0001 → fresh after 1 edge; ack=0001, rnd_out=0x00001, grant_id=0 on the next edge; grant_cnt=1.
- req=1111 held, giving ack then dropping each requester's bit the cycle after its ack and re-raising it; rnd_word steps through 0x00001, 0x00002, 0x00004, 0x00008, 0x00010, one every 21 clocks → grants in order 0, 1, 2, 3, 0 with rnd_out matching each word; no word delivered twice.
- rnd_word changes 0x00001→0x00003→0x00007 with req=0 → fresh=1 throughout, ack=0. Then req=0100 → single ack=0100 with rnd_out=0x00007; grant_cnt increments by 1 only.
- rnd_word changes on the same edge as a grant to requester 1, with req=0011 held → first ack=0010 with the old word; next edge ack=0001 with the new word.
- Assert rst while ack=1000 → ack=0, rnd_out=0, fresh=0 with no clock edge. After release, rnd_word held at 0x00000 → no ack despite req=1111.
- Hold req=0001 high continuously over 3 words → exactly 3 ack pulses, each one cycle wide, each exactly one edge after its word's fresh edge.
